// File: rtl/rv32i_pipe_core_p.sv
// rv32i_pipe_core_p: 5-stage (IF/ID/EX/MEM/WB) RV32I-subset core.
//   clk          rising-edge clock
//   RN           asynchronous active-high reset (also the IMEM load window)
//   imem_we/addr/wdata  IMEM write port, honoured only while RN=1
//   NPC          current fetch PC (word index)
//   WB_OUT       data of the last retired register write
//   wb_valid     one-cycle pulse per retired instruction
//   wb_rd        destination of the retired instruction (0 when none)
//   stall        IF/ID held by hazard logic this cycle
module rv32i_pipe_core_p #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned DMEM_DEPTH = 32,
  parameter bit          FWD_EN     = 1'b1,
  parameter bit          REG_INIT   = 1'b1
) (
  input  logic                          clk,
  input  logic                          RN,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   NPC,
  output logic [31:0]                   WB_OUT,
  output logic                          wb_valid,
  output logic [4:0]                    wb_rd,
  output logic                          stall
);
  localparam int unsigned IA_W = $clog2(IMEM_DEPTH);
  localparam int unsigned DA_W = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];

  logic [IA_W-1:0] pc;
  // IF/ID
  logic            ifid_valid;
  logic [IA_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  // ID/EX (rd/src are 0 when unused so they never match a hazard)
  logic            idex_valid, idex_is_lw, idex_is_sw, idex_is_br, idex_br_ne, idex_use_imm;
  logic [IA_W-1:0] idex_pc;
  logic [4:0]      idex_rd, idex_src1, idex_src2;
  logic [31:0]     idex_rv1, idex_rv2, idex_imm;
  alu_op_e         idex_alu;
  // EX/MEM
  logic            exmem_valid, exmem_is_lw, exmem_is_sw;
  logic [4:0]      exmem_rd;
  logic [31:0]     exmem_res, exmem_sdata;
  // MEM/WB
  logic            memwb_valid;
  logic [4:0]      memwb_rd;
  logic [31:0]     memwb_data;

  // ID decode
  logic [6:0]  d_opc, d_f7;
  logic [4:0]  d_rd, d_rs1, d_rs2, d_src1, d_src2, d_wrd;
  logic [2:0]  d_f3;
  logic        d_op_ok, d_addi, d_lw, d_sw, d_br, d_use1, d_use2;
  logic [31:0] d_imm, d_rv1, d_rv2;
  alu_op_e     d_alu;

  assign d_opc = ifid_instr[6:0];
  assign d_rd  = ifid_instr[11:7];
  assign d_f3  = ifid_instr[14:12];
  assign d_rs1 = ifid_instr[19:15];
  assign d_rs2 = ifid_instr[24:20];
  assign d_f7  = ifid_instr[31:25];

  assign d_op_ok = (d_opc == OPC_OP) &&
                   ((d_f7 == 7'h00 && d_f3 != 3'b011) || (d_f7 == 7'h20 && d_f3 == 3'b000));
  assign d_addi  = (d_opc == OPC_IMM)   && (d_f3 == 3'b000);
  assign d_lw    = (d_opc == OPC_LOAD)  && (d_f3 == 3'b010);
  assign d_sw    = (d_opc == OPC_STORE) && (d_f3 == 3'b010);
  assign d_br    = (d_opc == OPC_BR)    && (d_f3[2:1] == 2'b00);
  assign d_use1  = d_op_ok || d_addi || d_lw || d_sw || d_br;
  assign d_use2  = d_op_ok || d_sw || d_br;
  assign d_src1  = d_use1 ? d_rs1 : 5'd0;
  assign d_src2  = d_use2 ? d_rs2 : 5'd0;
  assign d_wrd   = (d_op_ok || d_addi || d_lw) ? d_rd : 5'd0;

  // Immediate select: S for stores, B for branches, I otherwise
  always_comb begin
    d_imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    if (d_sw)
      d_imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
    else if (d_br)
      d_imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
               ifid_instr[30:25], ifid_instr[11:8], 1'b0};
  end

  always_comb begin
    d_alu = ALU_ADD;
    if (d_op_ok) begin
      case (d_f3)
        3'b000:  d_alu = d_f7[5] ? ALU_SUB : ALU_ADD;
        3'b001:  d_alu = ALU_SLL;
        3'b010:  d_alu = ALU_SLT;
        3'b100:  d_alu = ALU_XOR;
        3'b101:  d_alu = ALU_SRL;
        3'b110:  d_alu = ALU_OR;
        3'b111:  d_alu = ALU_AND;
        default: d_alu = ALU_ADD;
      endcase
    end
  end

  // Register read with write-before-read bypass from the WB stage
  assign d_rv1 = (d_src1 == 5'd0) ? 32'd0 :
                 (memwb_rd == d_src1) ? memwb_data : rf[d_src1];
  assign d_rv2 = (d_src2 == 5'd0) ? 32'd0 :
                 (memwb_rd == d_src2) ? memwb_data : rf[d_src2];

  // EX: operand forwarding, ALU and branch resolution
  logic [31:0]     ex_a, ex_b, ex_opb, ex_res;
  logic            ex_take;
  logic [IA_W-1:0] ex_target;

  always_comb begin
    ex_a = idex_rv1;
    ex_b = idex_rv2;
    if (FWD_EN) begin
      if (exmem_rd != 5'd0 && exmem_rd == idex_src1)      ex_a = exmem_res;
      else if (memwb_rd != 5'd0 && memwb_rd == idex_src1) ex_a = memwb_data;
      if (exmem_rd != 5'd0 && exmem_rd == idex_src2)      ex_b = exmem_res;
      else if (memwb_rd != 5'd0 && memwb_rd == idex_src2) ex_b = memwb_data;
    end
  end

  assign ex_opb = idex_use_imm ? idex_imm : ex_b;

  always_comb begin
    case (idex_alu)
      ALU_ADD: ex_res = ex_a + ex_opb;
      ALU_SUB: ex_res = ex_a - ex_opb;
      ALU_AND: ex_res = ex_a & ex_opb;
      ALU_OR:  ex_res = ex_a | ex_opb;
      ALU_XOR: ex_res = ex_a ^ ex_opb;
      ALU_SLT: ex_res = {31'd0, ($signed(ex_a) < $signed(ex_opb))};
      ALU_SLL: ex_res = ex_a << ex_opb[4:0];
      ALU_SRL: ex_res = ex_a >> ex_opb[4:0];
      default: ex_res = ex_a + ex_opb;
    endcase
  end

  assign ex_take   = idex_valid && idex_is_br && ((ex_a == ex_b) != idex_br_ne);
  // Branch offset is in bytes; the PC counts words
  assign ex_target = idex_pc + IA_W'($signed(idex_imm) >>> 2);

  // Hazards: load-use only with forwarding, any EX/MEM RAW without it
  logic hz_ex, hz_mem, hazard_c;
  assign hz_ex    = (idex_rd != 5'd0)  && (idex_rd == d_src1  || idex_rd == d_src2);
  assign hz_mem   = (exmem_rd != 5'd0) && (exmem_rd == d_src1 || exmem_rd == d_src2);
  assign hazard_c = ifid_valid && (FWD_EN ? (hz_ex && idex_is_lw) : (hz_ex || hz_mem));
  assign stall    = hazard_c && !ex_take;

  assign NPC = 32'(pc);

  // IMEM load port, open only during reset
  always_ff @(posedge clk) begin
    if (RN && imem_we) imem[imem_addr] <= imem_wdata;
  end

  // DMEM store in MEM stage
  always_ff @(posedge clk) begin
    if (exmem_is_sw) dmem[exmem_res[DA_W+1:2]] <= exmem_sdata;
  end

  // Register file
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      for (int i = 0; i < 32; i++) rf[i] <= REG_INIT ? 32'(i) : 32'd0;
    end else if (memwb_rd != 5'd0) begin
      rf[memwb_rd] <= memwb_data;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      pc <= '0;
      ifid_valid <= 1'b0; ifid_pc <= '0; ifid_instr <= 32'd0;
      idex_valid <= 1'b0; idex_is_lw <= 1'b0; idex_is_sw <= 1'b0; idex_is_br <= 1'b0;
      idex_br_ne <= 1'b0; idex_use_imm <= 1'b0; idex_pc <= '0; idex_rd <= 5'd0;
      idex_src1 <= 5'd0; idex_src2 <= 5'd0; idex_rv1 <= 32'd0; idex_rv2 <= 32'd0;
      idex_imm <= 32'd0; idex_alu <= ALU_ADD;
      exmem_valid <= 1'b0; exmem_is_lw <= 1'b0; exmem_is_sw <= 1'b0; exmem_rd <= 5'd0;
      exmem_res <= 32'd0; exmem_sdata <= 32'd0;
      memwb_valid <= 1'b0; memwb_rd <= 5'd0; memwb_data <= 32'd0;
      wb_valid <= 1'b0; wb_rd <= 5'd0; WB_OUT <= 32'd0;
    end else begin
      // IF: taken branch redirects and squashes, a hazard holds PC and IF/ID
      if (ex_take) begin
        pc         <= ex_target;
        ifid_valid <= 1'b0;
      end else if (!hazard_c) begin
        pc         <= pc + 1'b1;
        ifid_valid <= 1'b1;
        ifid_pc    <= pc;
        ifid_instr <= imem[pc];
      end
      // ID -> EX: bubble on squash, stall or empty slot
      if (ex_take || hazard_c || !ifid_valid) begin
        idex_valid <= 1'b0; idex_rd <= 5'd0; idex_src1 <= 5'd0; idex_src2 <= 5'd0;
        idex_is_lw <= 1'b0; idex_is_sw <= 1'b0; idex_is_br <= 1'b0;
      end else begin
        idex_valid   <= 1'b1;
        idex_pc      <= ifid_pc;
        idex_rd      <= d_wrd;
        idex_src1    <= d_src1;
        idex_src2    <= d_src2;
        idex_rv1     <= d_rv1;
        idex_rv2     <= d_rv2;
        idex_imm     <= d_imm;
        idex_alu     <= d_alu;
        idex_is_lw   <= d_lw;
        idex_is_sw   <= d_sw;
        idex_is_br   <= d_br;
        idex_br_ne   <= d_f3[0];
        idex_use_imm <= d_addi || d_lw || d_sw;
      end
      // EX -> MEM
      exmem_valid <= idex_valid;
      exmem_rd    <= idex_rd;
      exmem_is_lw <= idex_is_lw;
      exmem_is_sw <= idex_is_sw;
      exmem_res   <= ex_res;
      exmem_sdata <= ex_b;
      // MEM -> WB
      memwb_valid <= exmem_valid;
      memwb_rd    <= exmem_rd;
      memwb_data  <= exmem_is_lw ? dmem[exmem_res[DA_W+1:2]] : exmem_res;
      // Retire
      wb_valid <= memwb_valid;
      wb_rd    <= memwb_rd;
      if (memwb_rd != 5'd0) WB_OUT <= memwb_data;
    end
  end

endmodule
